// File: rtl/program_loader.sv
// ---------------------------------------------------------------------------
// program_loader
//   Receives a byte stream that carries a load frame and writes the payload
//   words into a 256x16 program memory. The downstream machine is held in
//   reset until a complete frame has been written and its checksum matches.
//
//   Frame: HEADER, start address, word count N (0 = 256),
//          2N payload bytes (high byte, then low byte, per word),
//          checksum byte (XOR of the 2N payload bytes).
//
// Ports
//   clk        in   system clock, all state changes on the rising edge
//   rst        in   asynchronous reset, active low
//   in_valid   in   byte-stream data valid
//   in_data    in   byte-stream payload [7:0]
//   in_ready   out  loader can accept a byte (low only while writing a word)
//   mem_we     out  one-cycle memory write strobe
//   mem_addr   out  memory write address [7:0]
//   mem_wdata  out  memory write data [15:0]
//   cpu_rst    out  downstream reset, active low, released only after a good frame
//   done       out  last frame loaded and checksum verified
//   err        out  last frame failed its checksum
// ---------------------------------------------------------------------------
module program_loader #(
  parameter logic [7:0] HEADER = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_we,
  output logic [7:0]  mem_addr,
  output logic [15:0] mem_wdata,
  output logic        cpu_rst,
  output logic        done,
  output logic        err
);

  typedef enum logic [3:0] {
    IDLE, ADDR, COUNT, HI, LO, WRITE, CHECK, DONE, ERROR
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  addr_q,  addr_d;
  logic [8:0]  cnt_q,   cnt_d;    // remaining words, 1..256
  logic [7:0]  hi_q,    hi_d;
  logic [7:0]  lo_q,    lo_d;
  logic [7:0]  csum_q,  csum_d;
  logic        cpu_rst_q, cpu_rst_d;
  logic        done_q,  done_d;
  logic        err_q,   err_d;

  logic        accept;

  assign in_ready  = (state_q != WRITE);
  assign accept    = in_valid && in_ready;

  assign mem_we    = (state_q == WRITE);
  assign mem_addr  = addr_q;
  assign mem_wdata = {hi_q, lo_q};

  assign cpu_rst   = cpu_rst_q;
  assign done      = done_q;
  assign err       = err_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    csum_d  = csum_q;

    case (state_q)
      IDLE: begin
        if (accept && in_data == HEADER) state_d = ADDR;
      end
      ADDR: begin
        if (accept) begin
          addr_d  = in_data;
          state_d = COUNT;
        end
      end
      COUNT: begin
        if (accept) begin
          // A count byte of zero stands for a full 256-word image.
          cnt_d   = (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
          csum_d  = 8'd0;
          state_d = HI;
        end
      end
      HI: begin
        if (accept) begin
          hi_d    = in_data;
          csum_d  = csum_q ^ in_data;
          state_d = LO;
        end
      end
      LO: begin
        if (accept) begin
          lo_d    = in_data;
          csum_d  = csum_q ^ in_data;
          state_d = WRITE;
        end
      end
      WRITE: begin
        // Address rolls over 8'hFF -> 8'h00 naturally in 8 bits.
        addr_d  = addr_q + 8'd1;
        cnt_d   = cnt_q - 9'd1;
        state_d = (cnt_q == 9'd1) ? CHECK : HI;
      end
      CHECK: begin
        if (accept) state_d = (in_data == csum_q) ? DONE : ERROR;
      end
      DONE, ERROR: begin
        if (accept && in_data == HEADER) state_d = ADDR;
      end
      default: state_d = IDLE;
    endcase

    // Status flags are registered copies of the next state so that cpu_rst
    // is a clean flop output that tracks the DONE state exactly.
    cpu_rst_d = (state_d == DONE);
    done_d    = (state_d == DONE);
    err_d     = (state_d == ERROR);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      addr_q    <= 8'd0;
      cnt_q     <= 9'd0;
      hi_q      <= 8'd0;
      lo_q      <= 8'd0;
      csum_q    <= 8'd0;
      cpu_rst_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      csum_q    <= csum_d;
      cpu_rst_q <= cpu_rst_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

endmodule
